max7219_chain: RTL and testbench
================================

Name: max7219_chain

Overview:
Parametrised SPI write engine for a daisy chain of NUM_CHIPS MAX7219 LED drivers on one DIN/CLK/LOAD bus.
- Queues register writes in a small command FIFO.
- Sends each write as one 16*NUM_CHIPS-bit frame. The target chip gets the real word; every other chip gets a no-op (addr 0x0); broadcast mode gives every chip the same word.
- Programmable serial clock divider; LOAD pulse generated per frame.
- Sits between the display/clock formatting logic and the chip pins.

Parameters:
NUM_CHIPS, 2, number of cascaded MAX7219 devices (1..8).
CLK_DIV, 2, system clocks per serial-clock half period (>=1).
FIFO_DEPTH, 4, command FIFO entries (power of 2, >=2).

Ports:
i_clk  input  1  system clock
i_reset_n  input  1  asynchronous active-low reset
i_stb  input  1  write request; accepted when i_stb && o_ready
o_ready  output  1  FIFO not full
o_busy  output  1  FIFO non-empty or frame in progress
o_ack  output  1  one-cycle pulse when a frame's LOAD rises
i_bcast  input  1  1 = send {i_addr,i_data} to all chips
i_chip  input  3  target chip index, 0 = chip nearest the controller
i_addr  input  4  MAX7219 register address
i_data  input  8  register data
o_serial_dout  output  1  to DIN of chip 0
o_serial_load  output  1  LOAD/CS, idle high
o_serial_clk  output  1  serial clock, idle low

Behaviour:
- Reset (async assert, sync release): FIFO flushed, state IDLE, o_serial_load=1, o_serial_clk=0, o_serial_dout=0, o_ack=0, o_busy=0, o_ready=1. Assertion mid-frame aborts the frame immediately; no ack is issued.
- FIFO entry is {bcast, chip, addr, data}.
  - Write on accepted strobe.
  - i_stb while o_ready=0 is ignored; no overwrite.
  - Push and pop in the same cycle while full are not possible: o_ready is computed from the registered count.
- Frame building: 16-bit word W = {4'h0, addr, data}. Frame = concatenation of slots for chip NUM_CHIPS-1 down to chip 0, shifted MSB first, so chip 0's slot is sent last.
  - Slot for chip k = W if bcast or k == chip, else 16'h0000.
  - chip >= NUM_CHIPS with bcast=0 gives an all-no-op frame; it is still transmitted and acked.
- FSM IDLE -> SHIFT -> LATCH -> GAP -> IDLE.
  - IDLE: if FIFO non-empty, pop, load the shift register, go to SHIFT. o_serial_load falls on the same edge and o_serial_dout = frame MSB.
  - Latency: with the FIFO empty and the FSM idle, a strobe sampled at edge k gives LOAD low after edge k+1.
  - SHIFT: per bit, CLK_DIV cycles with clk=0 (data stable), then CLK_DIV cycles with clk=1. Data advances only at the clk 1->0 transition, giving CLK_DIV cycles of setup and hold.
  - SHIFT ends after 16*NUM_CHIPS rising edges, counted by a bit counter of width clog2(16*NUM_CHIPS+1).
  - LATCH: clk=0, load=0 for CLK_DIV cycles.
  - GAP: load=1 for CLK_DIV cycles; o_ack=1 only in the first GAP cycle; then IDLE. Minimum LOAD-high time between frames = CLK_DIV cycles.
- o_serial_clk is a registered output, not gated from i_clk.
- o_serial_dout holds the last bit until the next frame loads.
- Frames go out in strict FIFO order. Back-to-back frames have no extra idle cycles beyond GAP plus the one IDLE pop cycle.

Test Plan:
- NUM_CHIPS=2, CLK_DIV=2; write chip=0, addr=0x1, data=0xA5 -> 32 rising edges, captured DIN 0x000001A5, each clk high/low 2 cycles, one o_ack pulse, o_busy low 1 cycle after GAP ends.
- Same config, chip=1, addr=0xC, data=0x01 -> 0x0C010000. Broadcast addr=0xA, data=0x0F -> 0x0A0F0A0F.
- i_stb held high 10 consecutive cycles with data 0..9, FIFO_DEPTH=4 -> o_ready drops after the FIFO fills. Exactly the accepted writes appear as frames, in order, none duplicated. o_ack count equals accepted count.
- chip=5 with NUM_CHIPS=2, bcast=0 -> 0x00000000 frame sent, o_ack pulses once.
- i_reset_n low at bit 10 of a frame -> outputs at reset values within the same cycle (async). No ack. The queued second entry is discarded. The first frame after release is correct.
- CLK_DIV=1, NUM_CHIPS=1, addr=0xF, data=0x00 -> 16 edges with clk toggling every cycle, DIN 0x0F00, LOAD low for exactly 33 cycles.

Source files
------------

// File: rtl/max7219_chain_if.sv
// Command-side bus of the MAX7219 chain writer: one register write per accepted strobe.
// Handshake: a write transfers on every rising i_clk edge where stb && ready; stb while !ready is dropped, never queued.
interface max7219_chain_if;
  logic       stb;
  logic       ready;
  logic       busy;
  logic       ack;
  logic       bcast;
  logic [2:0] chip;
  logic [3:0] addr;
  logic [7:0] data;

  modport master (output stb, bcast, chip, addr, data, input ready, busy, ack);
  modport slave  (input stb, bcast, chip, addr, data, output ready, busy, ack);
endinterface

// File: rtl/max7219_chain.sv
// SPI write engine for a daisy chain of MAX7219 drivers: a small command FIFO feeds
// one 16*NUM_CHIPS-bit frame per write, with a divided serial clock and a LOAD pulse per frame.
module max7219_chain #(
  parameter int NUM_CHIPS  = 2,
  parameter int CLK_DIV    = 2,
  parameter int FIFO_DEPTH = 4
) (
  input  logic           i_clk,
  input  logic           i_reset_n,
  max7219_chain_if.slave cmd,
  output logic           o_serial_dout,
  output logic           o_serial_load,
  output logic           o_serial_clk,
  output logic [1:0]     o_dbg_state
);

  localparam int FRAME_BITS = 16 * NUM_CHIPS;
  localparam int BIT_W      = $clog2(FRAME_BITS + 1);
  localparam int DIV_W      = $clog2(CLK_DIV + 1);
  localparam int PTR_W      = $clog2(FIFO_DEPTH);

  localparam logic [BIT_W-1:0] BITS_TOTAL = BIT_W'(FRAME_BITS);
  localparam logic [DIV_W-1:0] DIV_LAST   = DIV_W'(CLK_DIV - 1);
  localparam logic [PTR_W:0]   FIFO_FULL  = (PTR_W + 1)'(FIFO_DEPTH);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_LATCH = 2'd2,
    ST_GAP   = 2'd3
  } state_t;

  state_t                  state;
  logic [15:0]             fifo_mem [FIFO_DEPTH];
  logic [PTR_W-1:0]        wr_ptr;
  logic [PTR_W-1:0]        rd_ptr;
  logic [PTR_W:0]          count;
  logic                    push;
  logic                    pop;
  logic [15:0]             head;
  logic [15:0]             word;
  logic [FRAME_BITS-1:0]   frame;
  logic [FRAME_BITS-1:0]   shreg;
  logic [BIT_W-1:0]        bit_cnt;
  logic [DIV_W-1:0]        div_cnt;
  logic                    ack_q;

  // ready comes from the registered count, so a full FIFO never sees push and pop together.
  assign cmd.ready   = (count != FIFO_FULL);
  assign cmd.busy    = (count != '0) || (state != ST_IDLE);
  assign cmd.ack     = ack_q;
  assign o_dbg_state = state;

  assign push = cmd.stb && cmd.ready;
  assign pop  = (state == ST_IDLE) && (count != '0);

  // Entry layout: {bcast, chip[2:0], addr[3:0], data[7:0]}.
  always_ff @(posedge i_clk) begin
    if (push) begin
      fifo_mem[wr_ptr] <= {cmd.bcast, cmd.chip, cmd.addr, cmd.data};
    end
  end

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Chip 0 sits nearest the controller, so its slot occupies the low bits and leaves last.
  always_comb begin
    head  = fifo_mem[rd_ptr];
    word  = {4'h0, head[11:0]};
    frame = '0;
    for (int k = 0; k < NUM_CHIPS; k++) begin
      if (head[15] || (head[14:12] == k[2:0])) begin
        frame[16*k +: 16] = word;
      end
    end
  end

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      state         <= ST_IDLE;
      shreg         <= '0;
      bit_cnt       <= '0;
      div_cnt       <= '0;
      o_serial_dout <= 1'b0;
      o_serial_load <= 1'b1;
      o_serial_clk  <= 1'b0;
      ack_q         <= 1'b0;
    end else begin
      ack_q <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (count != '0) begin
            shreg         <= frame;
            o_serial_dout <= frame[FRAME_BITS-1];
            o_serial_load <= 1'b0;
            o_serial_clk  <= 1'b0;
            div_cnt       <= '0;
            bit_cnt       <= '0;
            state         <= ST_SHIFT;
          end
        end
        ST_SHIFT: begin
          if (div_cnt == DIV_LAST) begin
            div_cnt <= '0;
            if (!o_serial_clk) begin
              o_serial_clk <= 1'b1;
              bit_cnt      <= bit_cnt + 1'b1;
            end else begin
              // Data moves only on the falling serial edge, giving a full half period of setup and hold.
              o_serial_clk <= 1'b0;
              if (bit_cnt == BITS_TOTAL) begin
                state <= ST_LATCH;
              end else begin
                shreg         <= {shreg[FRAME_BITS-2:0], 1'b0};
                o_serial_dout <= shreg[FRAME_BITS-2];
              end
            end
          end else begin
            div_cnt <= div_cnt + 1'b1;
          end
        end
        ST_LATCH: begin
          if (div_cnt == DIV_LAST) begin
            div_cnt       <= '0;
            o_serial_load <= 1'b1;
            ack_q         <= 1'b1;
            state         <= ST_GAP;
          end else begin
            div_cnt <= div_cnt + 1'b1;
          end
        end
        ST_GAP: begin
          if (div_cnt == DIV_LAST) begin
            div_cnt <= '0;
            state   <= ST_IDLE;
          end else begin
            div_cnt <= div_cnt + 1'b1;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_max7219_chain.sv
// Bench for max7219_chain: two instances (2 chips/div 2 and 1 chip/div 1) driven from a
// vector table, plus burst, no-op and mid-frame reset sequences.
module tb_max7219_chain;

  localparam int A_DIV   = 2;
  localparam int B_DIV   = 1;
  localparam int A_EDGES = 32;
  localparam int B_EDGES = 16;
  localparam int A_LOW   = 130;
  localparam int B_LOW   = 33;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst_a_n;
  logic rst_b_n;

  max7219_chain_if ifa ();
  max7219_chain_if ifb ();

  logic       a_dout, a_load, a_sclk;
  logic       b_dout, b_load, b_sclk;
  logic [1:0] a_state, b_state;

  max7219_chain #(.NUM_CHIPS(2), .CLK_DIV(A_DIV), .FIFO_DEPTH(4)) dut_a (
    .i_clk(clk), .i_reset_n(rst_a_n), .cmd(ifa),
    .o_serial_dout(a_dout), .o_serial_load(a_load), .o_serial_clk(a_sclk),
    .o_dbg_state(a_state)
  );

  max7219_chain #(.NUM_CHIPS(1), .CLK_DIV(B_DIV), .FIFO_DEPTH(4)) dut_b (
    .i_clk(clk), .i_reset_n(rst_b_n), .cmd(ifb),
    .o_serial_dout(b_dout), .o_serial_load(b_load), .o_serial_clk(b_sclk),
    .o_dbg_state(b_state)
  );

  // ---------------- pin monitors ----------------
  typedef struct {
    logic [31:0] data;
    int          edges;
    int          low;
    int          terr;
    int          gap;
    logic        ack_at_rise;
    logic        busy_at_rise;
  } rec_t;

  typedef struct {
    int          run;
    int          edges;
    int          low;
    int          terr;
    int          hi;
    int          gap;
    int          acks;
    logic [31:0] shift;
    logic        sclk_p;
    logic        load_p;
  } mon_t;

  mon_t ma, mb;
  rec_t a_got[$];
  rec_t b_got[$];

  task automatic mon_step(inout mon_t m, input logic rst_n, input logic load, input logic sclk,
                          input logic dout, input logic ack, input logic busy, input int div,
                          output logic pv, output rec_t r);
    pv = 1'b0;
    r  = '{default: 0};
    if (!rst_n) begin
      m.run = 0; m.edges = 0; m.low = 0; m.terr = 0; m.hi = 1000; m.gap = 0;
      m.shift = '0; m.sclk_p = 1'b0; m.load_p = 1'b1;
    end else begin
      if (ack) m.acks++;
      if (!load) begin
        if (m.load_p) begin
          m.run = 1; m.edges = 0; m.low = 1; m.terr = 0; m.shift = '0; m.gap = m.hi;
        end else begin
          m.low++;
          if (sclk == m.sclk_p) m.run++;
          else begin
            if (m.run != div) m.terr++;
            m.run = 1;
            if (sclk) begin
              m.edges++;
              m.shift = {m.shift[30:0], dout};
            end
          end
        end
      end else if (!m.load_p) begin
        if (m.run != div) m.terr++;
        pv = 1'b1;
        r = '{data: m.shift, edges: m.edges, low: m.low, terr: m.terr, gap: m.gap,
              ack_at_rise: ack, busy_at_rise: busy};
        m.hi = 1;
      end else begin
        m.hi++;
      end
      m.sclk_p = sclk;
      m.load_p = load;
    end
  endtask

  initial begin
    logic pv;
    rec_t r;
    ma.acks = 0;
    forever begin
      @(negedge clk);
      mon_step(ma, rst_a_n, a_load, a_sclk, a_dout, ifa.ack, ifa.busy, A_DIV, pv, r);
      if (pv) a_got.push_back(r);
    end
  end

  initial begin
    logic pv;
    rec_t r;
    mb.acks = 0;
    forever begin
      @(negedge clk);
      mon_step(mb, rst_b_n, b_load, b_sclk, b_dout, ifb.ack, ifb.busy, B_DIV, pv, r);
      if (pv) b_got.push_back(r);
    end
  end

  // ---------------- scoreboard ----------------
  int tests = 0;
  int fails = 0;
  logic [31:0] exp_q[$];

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    tests++;
    if (got !== want) begin
      fails++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", name, got, want);
    end
  endtask

  // ---------------- drivers ----------------
  task automatic send(input logic sel, input logic bcast, input logic [2:0] chip,
                      input logic [3:0] addr, input logic [7:0] data);
    @(negedge clk);
    if (sel) begin
      ifb.bcast = bcast; ifb.chip = chip; ifb.addr = addr; ifb.data = data; ifb.stb = 1'b1;
    end else begin
      ifa.bcast = bcast; ifa.chip = chip; ifa.addr = addr; ifa.data = data; ifa.stb = 1'b1;
    end
    @(negedge clk);
    ifa.stb = 1'b0;
    ifb.stb = 1'b0;
  endtask

  task automatic wait_rec(input logic sel, output rec_t r, output logic ok);
    ok = 1'b0;
    r  = '{default: 0};
    for (int i = 0; i < 5000; i++) begin
      @(posedge clk);
      if (sel && b_got.size() > 0) begin r = b_got.pop_front(); ok = 1'b1; break; end
      if (!sel && a_got.size() > 0) begin r = a_got.pop_front(); ok = 1'b1; break; end
    end
    check("frame_timeout", 32'(ok), 32'd1);
  endtask

  task automatic check_frame(input logic sel, input rec_t r, input string tag);
    logic [31:0] want;
    want = (exp_q.size() > 0) ? exp_q.pop_front() : 32'hDEAD_BEEF;
    check({tag, "_din"}, r.data, want);
    check({tag, "_edges"}, 32'(r.edges), sel ? 32'(B_EDGES) : 32'(A_EDGES));
    check({tag, "_load_low"}, 32'(r.low), sel ? 32'(B_LOW) : 32'(A_LOW));
    check({tag, "_sclk_timing"}, 32'(r.terr), 32'd0);
    check({tag, "_ack_at_load_rise"}, 32'(r.ack_at_rise), 32'd1);
    check({tag, "_busy_at_load_rise"}, 32'(r.busy_at_rise), 32'd1);
  endtask

  // ---------------- directed vectors ----------------
  typedef struct {
    logic        sel;
    logic        bcast;
    logic [2:0]  chip;
    logic [3:0]  addr;
    logic [7:0]  data;
    logic [31:0] exp_frame;
  } vec_t;

  vec_t vecs[10];

  initial begin
    rec_t r;
    logic ok;
    int   ack0;

    vecs[0] = '{1'b0, 1'b0, 3'd0, 4'h1, 8'hA5, 32'h0000_01A5};
    vecs[1] = '{1'b0, 1'b0, 3'd1, 4'hC, 8'h01, 32'h0C01_0000};
    vecs[2] = '{1'b0, 1'b1, 3'd0, 4'hA, 8'h0F, 32'h0A0F_0A0F};
    vecs[3] = '{1'b0, 1'b0, 3'd5, 4'h3, 8'h77, 32'h0000_0000};
    vecs[4] = '{1'b0, 1'b0, 3'd1, 4'hF, 8'hFF, 32'h0FFF_0000};
    vecs[5] = '{1'b0, 1'b1, 3'd3, 4'h4, 8'h3C, 32'h043C_043C};
    vecs[6] = '{1'b1, 1'b0, 3'd0, 4'hF, 8'h00, 32'h0000_0F00};
    vecs[7] = '{1'b1, 1'b1, 3'd3, 4'h2, 8'h5A, 32'h0000_025A};
    vecs[8] = '{1'b1, 1'b0, 3'd1, 4'h9, 8'hFF, 32'h0000_0000};
    vecs[9] = '{1'b1, 1'b0, 3'd0, 4'h1, 8'h81, 32'h0000_0181};

    ifa.stb = 1'b0; ifa.bcast = 1'b0; ifa.chip = '0; ifa.addr = '0; ifa.data = '0;
    ifb.stb = 1'b0; ifb.bcast = 1'b0; ifb.chip = '0; ifb.addr = '0; ifb.data = '0;
    rst_a_n = 1'b0;
    rst_b_n = 1'b0;
    repeat (3) @(negedge clk);

    check("rst_load", 32'(a_load), 32'd1);
    check("rst_sclk", 32'(a_sclk), 32'd0);
    check("rst_dout", 32'(a_dout), 32'd0);
    check("rst_ack", 32'(ifa.ack), 32'd0);
    check("rst_busy", 32'(ifa.busy), 32'd0);
    check("rst_ready", 32'(ifa.ready), 32'd1);
    check("rst_state", 32'(a_state), 32'd0);
    check("rst_b_load", 32'(b_load), 32'd1);
    check("rst_b_state", 32'(b_state), 32'd0);
    rst_a_n = 1'b1;
    rst_b_n = 1'b1;
    repeat (2) @(negedge clk);

    // Single writes from the table, each run to completion.
    for (int v = 0; v < 10; v++) begin
      ack0 = vecs[v].sel ? mb.acks : ma.acks;
      exp_q.push_back(vecs[v].exp_frame);
      send(vecs[v].sel, vecs[v].bcast, vecs[v].chip, vecs[v].addr, vecs[v].data);
      wait_rec(vecs[v].sel, r, ok);
      check_frame(vecs[v].sel, r, $sformatf("vec%0d", v));
      check($sformatf("vec%0d_acks", v), 32'((vecs[v].sel ? mb.acks : ma.acks) - ack0), 32'd1);
      repeat (vecs[v].sel ? B_DIV : A_DIV) @(negedge clk);
      check($sformatf("vec%0d_busy_after_gap", v),
            32'(vecs[v].sel ? ifb.busy : ifa.busy), 32'd0);
      check($sformatf("vec%0d_dout_hold", v),
            32'(vecs[v].sel ? b_dout : a_dout), 32'(vecs[v].exp_frame[0]));
    end

    // Burst: stb held 10 cycles; one entry popped at once, four queued, the rest dropped.
    ack0 = ma.acks;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      ifa.bcast = 1'b0; ifa.chip = 3'd0; ifa.addr = 4'h1; ifa.data = 8'(i); ifa.stb = 1'b1;
      check($sformatf("burst_ready%0d", i), 32'(ifa.ready), (i < 5) ? 32'd1 : 32'd0);
    end
    @(negedge clk);
    ifa.stb = 1'b0;
    for (int i = 0; i < 5; i++) exp_q.push_back({16'h0000, 8'h01, 8'(i)});
    for (int i = 0; i < 5; i++) begin
      wait_rec(1'b0, r, ok);
      check_frame(1'b0, r, $sformatf("burst%0d", i));
      if (i > 0) check($sformatf("burst%0d_load_high_gap", i), 32'(r.gap), 32'(A_DIV + 1));
    end
    repeat (400) @(negedge clk);
    check("burst_no_extra_frames", 32'(a_got.size()), 32'd0);
    check("burst_acks", 32'(ma.acks - ack0), 32'd5);
    check("burst_idle_busy", 32'(ifa.busy), 32'd0);

    // Mid-frame reset: first frame aborted at bit 10, queued second entry discarded.
    ack0 = ma.acks;
    send(1'b0, 1'b0, 3'd1, 4'hF, 8'hFF);
    send(1'b0, 1'b0, 3'd0, 4'h2, 8'h22);
    ok = 1'b0;
    for (int i = 0; i < 2000; i++) begin
      @(posedge clk);
      if (ma.edges == 10) begin ok = 1'b1; break; end
    end
    check("reset_reach_bit10", 32'(ok), 32'd1);
    check("reset_pre_dout", 32'(a_dout), 32'd1);
    #1 rst_a_n = 1'b0;
    #1;
    check("async_rst_load", 32'(a_load), 32'd1);
    check("async_rst_sclk", 32'(a_sclk), 32'd0);
    check("async_rst_dout", 32'(a_dout), 32'd0);
    check("async_rst_busy", 32'(ifa.busy), 32'd0);
    check("async_rst_ready", 32'(ifa.ready), 32'd1);
    check("async_rst_ack", 32'(ifa.ack), 32'd0);
    repeat (3) @(negedge clk);
    rst_a_n = 1'b1;
    repeat (400) @(negedge clk);
    check("reset_no_frame", 32'(a_got.size()), 32'd0);
    check("reset_no_ack", 32'(ma.acks - ack0), 32'd0);
    check("reset_queue_flushed", 32'(ifa.busy), 32'd0);
    check("reset_load_idle", 32'(a_load), 32'd1);

    exp_q.push_back(32'h0000_0733);
    send(1'b0, 1'b0, 3'd0, 4'h7, 8'h33);
    wait_rec(1'b0, r, ok);
    check_frame(1'b0, r, "post_reset");
    check("post_reset_acks", 32'(ma.acks - ack0), 32'd1);
    check("exp_q_drained", 32'(exp_q.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
